// File: rtl/usb_device_responder.sv
// Device-side responder for the host memory protocol: page address OUT, data OUT and data IN,
// bridging the USB packet decoder/encoder to a 64-bit paged memory.
module usb_device_responder #(
  parameter logic [6:0]  DEV_ADDR  = 7'd5,
  parameter logic [3:0]  ADDR_ENDP = 4'd4,
  parameter logic [3:0]  DATA_ENDP = 4'd8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [6:0]  rx_addr,
  input  logic [3:0]  rx_endp,
  input  logic [63:0] rx_data,
  input  logic        rx_crc_ok,
  output logic        tx_start,
  output logic [3:0]  tx_pid,
  output logic [63:0] tx_data,
  input  logic        tx_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_page,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic        page_valid,
  output logic        wr_done,
  output logic        rd_done
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimeoutCnt = TimerW'(TIMEOUT);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitData = 3'd1;
  localparam logic [2:0] StMemWrite = 3'd2;
  localparam logic [2:0] StMemRead  = 3'd3;
  localparam logic [2:0] StSend     = 3'd4;
  localparam logic [2:0] StWaitTx   = 3'd5;
  localparam logic [2:0] StWaitAck  = 3'd6;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;

  logic [2:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        endp_q, endp_d;
  logic [15:0]       page_q, page_d;
  logic              page_valid_q, page_valid_d;
  logic [3:0]        tx_pid_q, tx_pid_d;
  logic [63:0]       tx_data_q, tx_data_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              tx_start_q, tx_start_d;
  logic              rd_done_q, rd_done_d;
  logic              token_ok;

  assign token_ok = rx_valid & rx_crc_ok & (rx_addr == DEV_ADDR);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    endp_d       = endp_q;
    page_d       = page_q;
    page_valid_d = page_valid_q;
    tx_pid_d     = tx_pid_q;
    tx_data_d    = tx_data_q;
    wdata_d      = wdata_q;
    tx_start_d   = 1'b0;
    rd_done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (token_ok) begin
          if (rx_pid == PidOut && (rx_endp == ADDR_ENDP || rx_endp == DATA_ENDP)) begin
            state_d = StWaitData;
            endp_d  = rx_endp;
            timer_d = '0;
          end else if (rx_pid == PidIn && rx_endp == DATA_ENDP) begin
            if (page_valid_q) begin
              state_d = StMemRead;
            end else begin
              tx_pid_d = PidNak;
              state_d  = StSend;
            end
          end
        end
      end
      StWaitData: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid) begin
          // Bad CRC or unexpected PID: stay silent so the host times out and retries.
          if (rx_pid != PidData0 || !rx_crc_ok) begin
            state_d = StIdle;
          end else if (endp_q == ADDR_ENDP) begin
            page_d       = rx_data[63:48];
            page_valid_d = 1'b1;
            tx_pid_d     = PidAck;
            state_d      = StSend;
          end else if (page_valid_q) begin
            wdata_d = rx_data;
            state_d = StMemWrite;
          end else begin
            tx_pid_d = PidNak;
            state_d  = StSend;
          end
        end else if (timer_q == TimeoutCnt) begin
          state_d = StIdle;
        end
      end
      StMemWrite: begin
        if (mem_ready) begin
          tx_pid_d = PidAck;
          state_d  = StSend;
        end
      end
      StMemRead: begin
        if (mem_ready) begin
          tx_data_d = mem_rdata;
          tx_pid_d  = PidData0;
          state_d   = StSend;
        end
      end
      StSend: begin
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          timer_d = '0;
          state_d = (tx_pid_q == PidData0) ? StWaitAck : StIdle;
        end
      end
      StWaitAck: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid) begin
          rd_done_d = (rx_pid == PidAck) & rx_crc_ok;
          state_d   = StIdle;
        end else if (timer_q == TimeoutCnt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      endp_q       <= '0;
      page_q       <= '0;
      page_valid_q <= 1'b0;
      tx_pid_q     <= '0;
      tx_data_q    <= '0;
      wdata_q      <= '0;
      tx_start_q   <= 1'b0;
      rd_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      endp_q       <= endp_d;
      page_q       <= page_d;
      page_valid_q <= page_valid_d;
      tx_pid_q     <= tx_pid_d;
      tx_data_q    <= tx_data_d;
      wdata_q      <= wdata_d;
      tx_start_q   <= tx_start_d;
      rd_done_q    <= rd_done_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_pid     = tx_pid_q;
  assign tx_data    = tx_data_q;
  assign mem_rd     = (state_q == StMemRead);
  assign mem_wr     = (state_q == StMemWrite);
  assign mem_page   = page_q;
  assign mem_wdata  = wdata_q;
  assign page_valid = page_valid_q;
  assign wr_done    = mem_wr & mem_ready;
  assign rd_done    = rd_done_q;

endmodule

// File: tb/tb_usb_device_responder.sv
// Self-checking bench: directed scenarios plus random host transactions scored against a
// transaction-level model of the device (page register, page-valid flag, memory contents).
module tb_usb_device_responder;

  localparam logic [3:0] POut = 4'b0001, PIn = 4'b1001, PData0 = 4'b0011;
  localparam logic [3:0] PAck = 4'b0010, PNak = 4'b1010;

  logic clock = 1'b0, reset_n;
  logic rx_valid, rx_crc_ok, tx_start, tx_done, mem_rd, mem_wr, mem_ready;
  logic page_valid, wr_done, rd_done;
  logic [3:0] rx_pid, rx_endp, tx_pid;
  logic [6:0] rx_addr;
  logic [63:0] rx_data, tx_data, mem_wdata, mem_rdata;
  logic [15:0] mem_page;

  usb_device_responder dut (
    .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_pid(rx_pid),
    .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_data(rx_data), .rx_crc_ok(rx_crc_ok),
    .tx_start(tx_start), .tx_pid(tx_pid), .tx_data(tx_data), .tx_done(tx_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_page(mem_page), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .page_valid(page_valid),
    .wr_done(wr_done), .rd_done(rd_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Contents of never-written memory pages.
  function automatic logic [63:0] fill(input logic [15:0] p);
    return {p, ~p, p ^ 16'h5a5a, ~p ^ 16'h1234};
  endfunction

  // Environment: memory with programmable latency and a packet encoder.
  int mem_lat = 1, tx_lat = 1, mem_cnt = 0, tx_cnt = 0;
  bit tx_busy = 0;
  logic [63:0] env_mem [logic [15:0]];

  initial begin
    mem_ready = 0; mem_rdata = '0; tx_done = 0;
    forever begin
      @(posedge clock); #1;
      if (mem_rd || mem_wr) begin
        mem_cnt++;
        mem_ready = (mem_cnt == mem_lat);
        mem_rdata = env_mem.exists(mem_page) ? env_mem[mem_page] : fill(mem_page);
        if (mem_ready && mem_wr) env_mem[mem_page] = mem_wdata;
      end else begin
        mem_cnt = 0;
        mem_ready = 0;
      end
      tx_done = 0;
      if (tx_busy) begin
        if (tx_cnt >= tx_lat) begin
          tx_done = 1;
          tx_busy = 0;
        end else tx_cnt++;
      end
      if (tx_start) begin
        tx_busy = 1;
        tx_cnt = 0;
      end
    end
  end

  // Monitor, sampled mid-cycle.
  int n_tx = 0, n_txd = 0, n_wrcyc = 0, n_wrd = 0, n_rdd = 0;
  logic [3:0] last_pid;
  logic [63:0] last_data, last_wdata;
  logic [15:0] last_wpage;

  always @(negedge clock) begin
    if (tx_start) begin
      n_tx <= n_tx + 1;
      last_pid <= tx_pid;
      last_data <= tx_data;
    end
    if (tx_done) n_txd <= n_txd + 1;
    if (mem_wr) n_wrcyc <= n_wrcyc + 1;
    if (wr_done) begin
      n_wrd <= n_wrd + 1;
      last_wpage <= mem_page;
      last_wdata <= mem_wdata;
    end
    if (rd_done) n_rdd <= n_rdd + 1;
  end

  // Reference model state.
  bit m_pv = 0;
  logic [15:0] m_page = '0;
  logic [63:0] m_mem [logic [15:0]];

  function automatic logic [63:0] m_read(input logic [15:0] p);
    return m_mem.exists(p) ? m_mem[p] : fill(p);
  endfunction

  int tx0, txd0, wrc0, wrd0, rdd0;

  task automatic mark();
    tx0 = n_tx; txd0 = n_txd; wrc0 = n_wrcyc; wrd0 = n_wrd; rdd0 = n_rdd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e,
                          input logic [63:0] d, input bit crc);
    @(posedge clock); #1;
    rx_valid = 1; rx_pid = pid; rx_addr = a; rx_endp = e; rx_data = d; rx_crc_ok = crc;
    @(posedge clock); #1;
    rx_valid = 0; rx_crc_ok = 0;
  endtask

  task automatic expect_resp(input string tag, input bit exp_tx, input logic [3:0] exp_pid,
                             input bit chk_data, input logic [63:0] exp_data);
    if (exp_tx) begin
      for (int i = 0; i < 60 && n_txd == txd0; i++) idle(1);
      check_eq({tag, " tx_done seen"}, 64'(n_txd - txd0), 64'd1);
      check_eq({tag, " tx count"}, 64'(n_tx - tx0), 64'd1);
      check_eq({tag, " pid"}, 64'(last_pid), 64'(exp_pid));
      if (chk_data) check_eq({tag, " payload"}, last_data, exp_data);
    end else begin
      idle(8);
      check_eq({tag, " silent"}, 64'(n_tx - tx0), 64'd0);
    end
  endtask

  task automatic do_addr(input logic [15:0] pg, input bit chk_lat);
    mark();
    send_pkt(POut, 7'd5, 4'd4, '0, 1);
    send_pkt(PData0, 7'd0, 4'd0, {pg, 16'($urandom), $urandom}, 1);
    if (chk_lat) begin
      check_eq("ack latency c1", 64'(tx_start), 64'd0);
      idle(1);
      check_eq("ack latency c2", 64'(tx_start), 64'd1);
    end
    m_page = pg;
    m_pv = 1;
    expect_resp("addr", 1, PAck, 0, '0);
    check_eq("addr page_valid", 64'(page_valid), 64'd1);
    check_eq("addr mem_page", 64'(mem_page), 64'(m_page));
  endtask

  task automatic do_write(input logic [63:0] d);
    mark();
    send_pkt(POut, 7'd5, 4'd8, '0, 1);
    send_pkt(PData0, 7'd0, 4'd0, d, 1);
    if (m_pv) begin
      expect_resp("write", 1, PAck, 0, '0);
      check_eq("write wr_done", 64'(n_wrd - wrd0), 64'd1);
      check_eq("write mem_wr cycles", 64'(n_wrcyc - wrc0), 64'(mem_lat));
      check_eq("write page", 64'(last_wpage), 64'(m_page));
      check_eq("write data", last_wdata, d);
      m_mem[m_page] = d;
    end else begin
      expect_resp("write nopage", 1, PNak, 0, '0);
      check_eq("write nopage mem_wr", 64'(n_wrcyc - wrc0), 64'd0);
    end
  endtask

  task automatic do_read(input bit host_ack);
    mark();
    send_pkt(PIn, 7'd5, 4'd8, '0, 1);
    if (m_pv) begin
      expect_resp("read", 1, PData0, 1, m_read(m_page));
      if (host_ack) begin
        send_pkt(PAck, 7'd0, 4'd0, '0, 1);
        idle(3);
        check_eq("read rd_done", 64'(n_rdd - rdd0), 64'd1);
      end
    end else begin
      expect_resp("read nopage", 1, PNak, 0, '0);
    end
  endtask

  task automatic do_drop(input int kind);
    mark();
    case (kind)
      0: begin
        send_pkt(POut, 7'd6, 4'd4, '0, 1);
        send_pkt(PData0, 7'd0, 4'd0, 64'h1111_0000_0000_0000, 1);
      end
      1: begin
        send_pkt(POut, 7'd5, 4'd4, '0, 1);
        send_pkt(PData0, 7'd0, 4'd0, 64'h2222_0000_0000_0000, 0);
      end
      2: send_pkt(PIn, 7'd5, 4'd8, '0, 0);
      default: begin
        send_pkt(POut, 7'd5, 4'd3, '0, 1);
        send_pkt(PData0, 7'd0, 4'd0, 64'h3333_0000_0000_0000, 1);
      end
    endcase
    expect_resp($sformatf("drop%0d", kind), 0, '0, 0, '0);
    check_eq("drop page_valid", 64'(page_valid), 64'(m_pv));
    check_eq("drop mem_page", 64'(mem_page), 64'(m_page));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 0; rx_valid = 0; rx_pid = '0; rx_addr = '0; rx_endp = '0; rx_data = '0;
    rx_crc_ok = 0;
    idle(2);
    check_eq("reset tx_start", 64'(tx_start), 64'd0);
    check_eq("reset mem_rd/mem_wr", 64'({mem_rd, mem_wr}), 64'd0);
    check_eq("reset page_valid", 64'(page_valid), 64'd0);
    check_eq("reset mem_page", 64'(mem_page), 64'd0);
    check_eq("reset tx_pid", 64'(tx_pid), 64'd0);
    check_eq("reset pulses", 64'({wr_done, rd_done}), 64'd0);
    reset_n = 1;
    idle(2);

    // Without a page: IN and data OUT are refused.
    mark();
    send_pkt(PIn, 7'd5, 4'd8, '0, 1);
    check_eq("nak latency c1", 64'(tx_start), 64'd0);
    idle(1);
    check_eq("nak latency c2", 64'(tx_start), 64'd1);
    expect_resp("in nopage", 1, PNak, 0, '0);
    do_write(64'h5555_6666_7777_8888);

    // Silent cases and WAIT_DATA timeout.
    for (int k = 0; k < 4; k++) do_drop(k);
    mark();
    send_pkt(POut, 7'd5, 4'd4, '0, 1);
    idle(300);
    send_pkt(PData0, 7'd0, 4'd0, 64'h4444_0000_0000_0000, 1);
    expect_resp("data after timeout", 0, '0, 0, '0);
    check_eq("timeout page_valid", 64'(page_valid), 64'd0);

    // Late but in-window DATA0 is still accepted.
    mark();
    send_pkt(POut, 7'd5, 4'd4, '0, 1);
    idle(200);
    send_pkt(PData0, 7'd0, 4'd0, 64'h0042_0000_0000_0000, 1);
    m_page = 16'h0042;
    m_pv = 1;
    expect_resp("late addr", 1, PAck, 0, '0);

    do_addr(16'hBEEF, 1);
    mem_lat = 3;
    do_write(64'h0123_4567_89AB_CDEF);

    // Preload external memory so the read returns a known pattern.
    env_mem[16'hBEEF] = 64'hCAFE_F00D_DEAD_BEEF;
    m_mem[16'hBEEF] = 64'hCAFE_F00D_DEAD_BEEF;
    mem_lat = 2;
    do_read(1);
    do_read(0);
    idle(300);
    check_eq("ack timeout rd_done", 64'(n_rdd - rdd0), 64'd0);
    do_read(1);

    // Asynchronous reset during a held write.
    mem_lat = 50;
    mark();
    send_pkt(POut, 7'd5, 4'd8, '0, 1);
    send_pkt(PData0, 7'd0, 4'd0, 64'h9999_AAAA_BBBB_CCCC, 1);
    idle(3);
    check_eq("pre-reset mem_wr", 64'(mem_wr), 64'd1);
    #2 reset_n = 0;
    #1;
    check_eq("async reset mem_wr", 64'(mem_wr), 64'd0);
    check_eq("async reset page_valid", 64'(page_valid), 64'd0);
    check_eq("async reset wr_done", 64'(wr_done), 64'd0);
    idle(2);
    reset_n = 1;
    m_pv = 0;
    m_page = '0;
    idle(2);
    check_eq("reset aborted write", 64'(n_wrd - wrd0), 64'd0);
    do_read(1);

    // Random host traffic.
    for (int t = 0; t < 40; t++) begin
      int k;
      logic [15:0] pg;
      mem_lat = $urandom_range(1, 4);
      tx_lat = $urandom_range(1, 3);
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0: pg = 16'h0001;
        1: pg = 16'h0002;
        default: pg = 16'hBEEF;
      endcase
      if (k < 2) do_addr(pg, 0);
      else if (k < 5) do_write({$urandom, $urandom});
      else if (k < 8) do_read(1);
      else do_drop($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
